spi_master_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares one SPI transaction engine (address phase, then NoD data words, then end phase) among NREQ requesters inside the CNN accelerator.
- Grants the engine to one requester at a time and muxes that requester's addr/wr_data/NoD/SCK_div onto it.
- Issues the one-cycle start pulse.
- Forwards every received data word back to the granted requester with a valid strobe.
- Closes each transaction with done/err pulses, including a word-count check.

---
 rtl/spi_master_arbiter.sv | 201 ++++++++++++++++++++
 tb/tb_spi_master_arbiter.sv | 362 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_master_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : spi_master_arbiter
// Description : Round-robin arbiter/sequencer sharing one SPI transaction
//               engine among NREQ requesters. Muxes the granted requester's
//               transaction fields onto the engine, issues the start pulse,
//               returns received words and closes each transaction with
//               done/err (including a word-count check).
// Revision    : 1.0 - initial release
// ============================================================================
module spi_master_arbiter #(
  parameter int NREQ   = 4,
  parameter int DWIDTH = 16
) (
  input  logic                   clk,
  input  logic                   nRst,
  input  logic [NREQ-1:0]        req,
  input  logic [NREQ*DWIDTH-1:0] req_addr,
  input  logic [NREQ*DWIDTH-1:0] req_wr_data,
  input  logic [NREQ*16-1:0]     req_nod,
  input  logic [NREQ*8-1:0]      req_sck_div,
  output logic [NREQ-1:0]        gnt,
  output logic [NREQ-1:0]        rd_valid,
  output logic [DWIDTH-1:0]      rd_data,
  output logic [NREQ-1:0]        done,
  output logic                   err,
  output logic                   eng_start,
  output logic [DWIDTH-1:0]      eng_addr,
  output logic [DWIDTH-1:0]      eng_wr_data,
  output logic [15:0]            eng_nod,
  output logic [7:0]             eng_sck_div,
  input  logic                   eng_busy,
  input  logic                   eng_done,
  input  logic                   eng_spi_done,
  input  logic [2:0]             eng_state,
  input  logic [DWIDTH-1:0]      eng_rd_data
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_LAUNCH = 2'd1;
  localparam logic [1:0] S_ACTIVE = 2'd2;

  // Engine phase code for the data-word phase.
  localparam logic [2:0] ENG_DATA_PHASE = 3'b011;

  // Per-requester views of the flattened request buses.
  logic [DWIDTH-1:0] addr_a [NREQ];
  logic [DWIDTH-1:0] wr_a   [NREQ];
  logic [15:0]       nod_a  [NREQ];
  logic [7:0]        div_a  [NREQ];

  logic [1:0]        state_q,    state_d;
  logic [IW-1:0]     gidx_q,     gidx_d;
  logic [IW-1:0]     last_q,     last_d;
  logic [15:0]       wcnt_q,     wcnt_d;
  logic              wflag_q,    wflag_d;
  logic [NREQ-1:0]   gnt_q,      gnt_d;
  logic [NREQ-1:0]   rd_valid_q, rd_valid_d;
  logic [DWIDTH-1:0] rd_data_q,  rd_data_d;
  logic [NREQ-1:0]   done_q,     done_d;
  logic              err_q,      err_d;
  logic              start_q,    start_d;

  logic              sel_found;
  logic [IW-1:0]     sel_idx;
  logic [IW-1:0]     cand;
  logic [15:0]       wcnt_fin;
  logic              gnt_any;

  genvar g;
  generate
    for (g = 0; g < NREQ; g++) begin : g_unpack
      assign addr_a[g] = req_addr[g*DWIDTH +: DWIDTH];
      assign wr_a[g]   = req_wr_data[g*DWIDTH +: DWIDTH];
      assign nod_a[g]  = req_nod[g*16 +: 16];
      assign div_a[g]  = req_sck_div[g*8 +: 8];
    end
  endgenerate

  // Round-robin pick: first active request strictly after the last one served.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    cand      = '0;
    for (int k = 1; k <= NREQ; k++) begin
      cand = IW'((int'(last_q) + k) % NREQ);
      if (!sel_found && req[cand]) begin
        sel_found = 1'b1;
        sel_idx   = cand;
      end
    end
  end

  // Word count including a word whose flag is still pending at this edge.
  assign wcnt_fin = wcnt_q + 16'(wflag_q);

  // Sequencer next-state: arbitration in IDLE, start pulse, data/done tracking.
  always_comb begin
    state_d    = state_q;
    gidx_d     = gidx_q;
    last_d     = last_q;
    wcnt_d     = wcnt_q;
    wflag_d    = wflag_q;
    gnt_d      = gnt_q;
    rd_valid_d = '0;
    rd_data_d  = rd_data_q;
    done_d     = '0;
    err_d      = 1'b0;
    start_d    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (sel_found && !eng_busy) begin
          last_d = sel_idx;
          if (nod_a[sel_idx] == 16'd0) begin
            // Zero-length request is rejected without touching the engine.
            done_d[sel_idx] = 1'b1;
            err_d           = 1'b1;
          end else begin
            gidx_d         = sel_idx;
            wcnt_d         = 16'd0;
            wflag_d        = 1'b0;
            gnt_d          = '0;
            gnt_d[sel_idx] = 1'b1;
            start_d        = 1'b1;
            state_d        = S_LAUNCH;
          end
        end
      end
      S_LAUNCH: begin
        state_d = S_ACTIVE;
      end
      S_ACTIVE: begin
        wflag_d = eng_spi_done && (eng_state == ENG_DATA_PHASE);
        if (wflag_q) begin
          rd_data_d          = eng_rd_data;
          rd_valid_d[gidx_q] = 1'b1;
          wcnt_d             = wcnt_fin;
        end
        if (eng_done) begin
          gnt_d          = '0;
          done_d[gidx_q] = 1'b1;
          err_d          = (wcnt_fin != nod_a[gidx_q]);
          wflag_d        = 1'b0;
          state_d        = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and output registers; reset returns to IDLE with requester 0 first in line.
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      state_q    <= S_IDLE;
      gidx_q     <= '0;
      last_q     <= IW'(NREQ - 1);
      wcnt_q     <= 16'd0;
      wflag_q    <= 1'b0;
      gnt_q      <= '0;
      rd_valid_q <= '0;
      rd_data_q  <= '0;
      done_q     <= '0;
      err_q      <= 1'b0;
      start_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      gidx_q     <= gidx_d;
      last_q     <= last_d;
      wcnt_q     <= wcnt_d;
      wflag_q    <= wflag_d;
      gnt_q      <= gnt_d;
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
      done_q     <= done_d;
      err_q      <= err_d;
      start_q    <= start_d;
    end
  end

  assign gnt_any = |gnt_q;

  assign gnt       = gnt_q;
  assign rd_valid  = rd_valid_q;
  assign rd_data   = rd_data_q;
  assign done      = done_q;
  assign err       = err_q;
  assign eng_start = start_q;

  // Engine-facing fields follow the granted requester live; write data is
  // deliberately unregistered so the requester can advance it per word.
  assign eng_addr    = gnt_any ? addr_a[gidx_q] : '0;
  assign eng_wr_data = gnt_any ? wr_a[gidx_q]   : '0;
  assign eng_nod     = gnt_any ? nod_a[gidx_q]  : 16'd0;
  assign eng_sck_div = gnt_any ? div_a[gidx_q]  : 8'd0;

endmodule
`default_nettype wire

// File: tb/tb_spi_master_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_spi_master_arbiter
// Description : Scoreboard bench for spi_master_arbiter with a behavioural
//               SPI engine, auto-dropping requesters and a round-robin
//               reference model that plans the expected transaction order.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_spi_master_arbiter;

  localparam int NREQ = 4;
  localparam int DW   = 16;

  typedef struct {
    int idx;
    int nod;
    int nwords;
    bit err;
  } txn_t;

  logic              clk;
  logic              nRst;
  logic [NREQ-1:0]   req;
  logic [NREQ*DW-1:0] req_addr;
  logic [NREQ*DW-1:0] req_wr_data;
  logic [NREQ*16-1:0] req_nod;
  logic [NREQ*8-1:0]  req_sck_div;
  logic [NREQ-1:0]   gnt, rd_valid, done;
  logic [DW-1:0]     rd_data;
  logic              err, eng_start;
  logic [DW-1:0]     eng_addr, eng_wr_data;
  logic [15:0]       eng_nod;
  logic [7:0]        eng_sck_div;
  logic              eng_busy     = 1'b0;
  logic              eng_done     = 1'b0;
  logic              eng_spi_done = 1'b0;
  logic [2:0]        eng_state    = 3'b000;
  logic [DW-1:0]     eng_rd_data  = '0;

  spi_master_arbiter #(.NREQ(NREQ), .DWIDTH(DW)) dut (
    .clk(clk), .nRst(nRst), .req(req), .req_addr(req_addr),
    .req_wr_data(req_wr_data), .req_nod(req_nod), .req_sck_div(req_sck_div),
    .gnt(gnt), .rd_valid(rd_valid), .rd_data(rd_data), .done(done), .err(err),
    .eng_start(eng_start), .eng_addr(eng_addr), .eng_wr_data(eng_wr_data),
    .eng_nod(eng_nod), .eng_sck_div(eng_sck_div), .eng_busy(eng_busy),
    .eng_done(eng_done), .eng_spi_done(eng_spi_done), .eng_state(eng_state),
    .eng_rd_data(eng_rd_data)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_checks = 0;
  int n_fail   = 0;

  txn_t       exp_txn[$];
  logic [15:0] exp_data[$];
  logic [15:0] cap_wr[$];

  // Requester bookkeeping: a requester asks while served < target.
  int          served [NREQ];
  int          target [NREQ];
  int          pend   [NREQ];
  int          nod_v  [NREQ];
  logic [15:0] addr_v [NREQ];
  logic [7:0]  div_v  [NREQ];
  logic [15:0] wr_base[NREQ];
  logic [15:0] wr_adv [NREQ];
  int          m_last;
  bit          short_mode = 1'b0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, want);
    end
  endtask

  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      req[i]                  = served[i] < target[i];
      req_addr[i*DW +: DW]    = addr_v[i];
      req_wr_data[i*DW +: DW] = wr_base[i] + wr_adv[i];
      req_nod[i*16 +: 16]     = 16'(nod_v[i]);
      req_sck_div[i*8 +: 8]   = div_v[i];
    end
  end

  // Reference round-robin rule: first requester after 'last', wrapping.
  function automatic int rr_pick(input int last, input logic [NREQ-1:0] m);
    for (int k = 1; k <= NREQ; k++) begin
      int j;
      j = (last + k) % NREQ;
      if (m[j]) return j;
    end
    return -1;
  endfunction

  // Requesters: count completions, advance write word on each rd_valid.
  always @(negedge clk) begin
    if (nRst) begin
      for (int i = 0; i < NREQ; i++) begin
        if (done[i]) served[i] = served[i] + 1;
        if (rd_valid[i]) wr_adv[i] = wr_adv[i] + 16'd1;
      end
    end
  end

  // Behavioural SPI engine: addr phase, data words, end phase, done pulse.
  int e_phase = 0, e_cnt = 0, e_words = 0, e_target = 0;
  always @(negedge clk) begin
    if (!nRst) begin
      e_phase = 0; e_cnt = 0; e_words = 0;
      eng_busy = 1'b0; eng_done = 1'b0; eng_spi_done = 1'b0;
      eng_state = 3'b000; eng_rd_data = '0;
    end else begin
      eng_spi_done = 1'b0;
      eng_done     = 1'b0;
      if (eng_start) check("eng_start_while_busy", eng_busy, 0);
      case (e_phase)
        0: if (eng_start) begin
          eng_busy = 1'b1; e_target = short_mode ? 2 : int'(eng_nod);
          e_phase = 1; e_cnt = 0; e_words = 0; eng_state = 3'b001;
        end
        1: begin
          e_cnt++;
          if (e_cnt == 3) begin e_phase = 2; e_cnt = 0; eng_state = 3'b011; end
        end
        2: if (e_words == e_target) begin
          e_phase = 3; e_cnt = 0; eng_state = 3'b100;
        end else begin
          e_cnt++;
          if (e_cnt == 4) begin
            e_cnt = 0;
            eng_rd_data = 16'($urandom);
            exp_data.push_back(eng_rd_data);
            cap_wr.push_back(eng_wr_data);
            eng_spi_done = 1'b1;
            e_words++;
          end
        end
        3: begin
          e_cnt++;
          if (e_cnt == 2) begin eng_done = 1'b1; e_phase = 4; end
        end
        default: begin eng_busy = 1'b0; eng_state = 3'b000; e_phase = 0; end
      endcase
    end
  end

  // Monitor: pops expectations whenever the DUT presents grant/data/done.
  logic [NREQ-1:0] gnt_prev = '0;
  int mon_words = 0, mon_starts = 0;
  bit mon_granted = 1'b0;
  always @(negedge clk) begin
    if (!nRst) begin
      gnt_prev = '0; mon_words = 0; mon_starts = 0; mon_granted = 1'b0;
      exp_txn.delete(); exp_data.delete();
    end else begin
      if (eng_start) mon_starts++;
      if (gnt != 0 && gnt_prev == 0) begin
        mon_granted = 1'b1;
        mon_words   = 0;
        if (exp_txn.size() == 0) check("unexpected_grant", gnt, 0);
        else begin
          check("grant_idx", gnt, 64'(1) << exp_txn[0].idx);
          check("eng_addr", eng_addr, addr_v[exp_txn[0].idx]);
          check("eng_nod", eng_nod, 16'(nod_v[exp_txn[0].idx]));
          check("eng_sck_div", eng_sck_div, div_v[exp_txn[0].idx]);
        end
      end
      if (gnt != 0) check("gnt_onehot", $onehot(gnt), 1);
      if (rd_valid != 0) begin
        if (exp_data.size() == 0 || exp_txn.size() == 0) check("unexpected_rd_valid", rd_valid, 0);
        else begin
          check("rd_valid_idx", rd_valid, 64'(1) << exp_txn[0].idx);
          check("rd_data", rd_data, exp_data.pop_front());
        end
        mon_words++;
        if (done != 0) check("rd_valid_with_done", 1, 0);
      end
      if (done != 0) begin
        if (exp_txn.size() == 0) check("unexpected_done", done, 0);
        else begin
          txn_t t;
          t = exp_txn.pop_front();
          check("done_idx", done, 64'(1) << t.idx);
          check("err", err, t.err);
          check("word_count", mon_words, t.nwords);
          check("gnt_dropped", gnt, 0);
          check("start_count", mon_starts, (t.nod == 0) ? 0 : 1);
          check("granted", mon_granted, (t.nod == 0) ? 0 : 1);
        end
        mon_words = 0; mon_starts = 0; mon_granted = 1'b0;
      end else if (err) begin
        check("err_without_done", err, 0);
      end
      gnt_prev = gnt;
    end
  end

  task automatic setup(input int i, input int nod, input logic [15:0] a, input logic [7:0] d, input int n);
    nod_v[i] = nod; addr_v[i] = a; div_v[i] = d; pend[i] = n;
  endtask

  // Plan the expected service order for all pending requests raised together.
  task automatic plan();
    int rem[NREQ];
    logic [NREQ-1:0] m;
    txn_t t;
    for (int i = 0; i < NREQ; i++) rem[i] = pend[i];
    for (int n = 0; n < 64; n++) begin
      for (int i = 0; i < NREQ; i++) m[i] = rem[i] > 0;
      if (m == 0) break;
      t.idx = rr_pick(m_last, m);
      t.nod = nod_v[t.idx]; t.nwords = nod_v[t.idx]; t.err = (nod_v[t.idx] == 0);
      exp_txn.push_back(t);
      m_last = t.idx;
      rem[t.idx]--;
    end
  endtask

  task automatic raise();
    for (int i = 0; i < NREQ; i++) begin
      target[i] = served[i] + pend[i];
      pend[i]   = 0;
    end
  endtask

  task automatic drain(input int limit);
    int c = 0;
    while ((exp_txn.size() != 0 || eng_busy || req != 0) && c < limit) begin
      @(negedge clk); c++;
    end
    if (c >= limit) begin
      n_checks++; n_fail++;
      $display("FAIL drain_timeout: %0d transactions still outstanding", exp_txn.size());
      exp_txn.delete(); exp_data.delete();
      for (int i = 0; i < NREQ; i++) target[i] = served[i];
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic do_reset();
    nRst = 1'b0;
    for (int i = 0; i < NREQ; i++) begin target[i] = served[i]; pend[i] = 0; end
    repeat (3) @(negedge clk);
    nRst = 1'b1;
    m_last = NREQ - 1;
  endtask

  initial begin
    txn_t t;
    int c;
    nRst = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      served[i] = 0; target[i] = 0; pend[i] = 0; nod_v[i] = 1;
      addr_v[i] = 16'(16'h1000 + i); div_v[i] = 8'd2; wr_base[i] = '0; wr_adv[i] = '0;
    end
    m_last = NREQ - 1;
    repeat (3) @(negedge clk);
    check("rst_gnt", gnt, 0);
    check("rst_rd_valid", rd_valid, 0);
    check("rst_done_err", {done, err}, 0);
    check("rst_eng_start", eng_start, 0);
    check("rst_rd_data", rd_data, 0);
    check("rst_eng_mux", {eng_addr, eng_nod, eng_sck_div}, 0);
    nRst = 1'b1;

    // Single request with latency check on grant.
    setup(2, 3, 16'hA5A5, 8'd1, 1);
    plan(); raise();
    @(negedge clk);
    check("single_gnt_latency", gnt, 4'b0100);
    drain(500);

    // Contention from reset: 0,1,2,3,0.
    do_reset();
    for (int i = 0; i < NREQ; i++) setup(i, 1, 16'(16'h2000 + i), 8'(i + 3), (i == 0) ? 2 : 1);
    plan(); raise();
    drain(1000);

    // Zero-length request, then a normal one from the same requester.
    setup(1, 0, 16'h3333, 8'd4, 1);
    plan(); raise();
    drain(200);
    setup(1, 2, 16'h3334, 8'd4, 1);
    plan(); raise();
    drain(500);

    // Engine ends early: 2 words against nod=4.
    short_mode = 1'b1;
    setup(3, 4, 16'h4444, 8'd5, 1);
    t.idx = 3; t.nod = 4; t.nwords = 2; t.err = 1'b1;
    exp_txn.push_back(t);
    m_last = 3;
    raise();
    drain(500);
    short_mode = 1'b0;

    // Streaming write 0001..0004.
    wr_base[0] = 16'd1 - wr_adv[0];
    setup(0, 4, 16'h5555, 8'd1, 1);
    cap_wr.delete();
    plan(); raise();
    drain(500);
    check("stream_len", cap_wr.size(), 4);
    for (int k = 0; k < 4; k++)
      check("stream_word", (cap_wr.size() > k) ? cap_wr[k] : 16'hxxxx, 16'(k + 1));

    // Random rounds.
    for (int r = 0; r < 8; r++) begin
      logic [NREQ-1:0] m;
      m = NREQ'($urandom_range(1, (1 << NREQ) - 1));
      for (int i = 0; i < NREQ; i++) begin
        wr_base[i] = 16'($urandom);
        setup(i, int'($urandom_range(0, 3)), 16'($urandom), 8'($urandom), m[i] ? 1 : 0);
      end
      plan(); raise();
      drain(2000);
    end

    // Reset during ACTIVE with word 2 of 5 pending.
    setup(2, 5, 16'h6666, 8'd2, 1);
    plan(); raise();
    c = 0;
    while (!rd_valid[2] && c < 300) begin @(negedge clk); c++; end
    check("midrst_first_word_seen", rd_valid[2], 1);
    @(negedge clk);
    nRst = 1'b0;
    for (int i = 0; i < NREQ; i++) target[i] = served[i];
    #1;
    check("midrst_gnt", gnt, 0);
    check("midrst_pulses", {rd_valid, done, err, eng_start}, 0);
    check("midrst_rd_data", rd_data, 0);
    check("midrst_eng_mux", {eng_addr, eng_wr_data, eng_nod, eng_sck_div}, 0);
    repeat (3) begin
      @(negedge clk);
      check("midrst_no_done", done, 0);
    end
    nRst = 1'b1;
    m_last = NREQ - 1;
    setup(0, 1, 16'h7770, 8'd1, 1);
    setup(1, 1, 16'h7771, 8'd1, 1);
    plan(); raise();
    drain(500);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, %0d failures so far", n_fail);
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
